// File: rtl/sd_spi_master.sv
// Memory-mapped, byte-wide, mode-0 SPI master for the SD card with a programmable SCLK divider.
// Defining SPI_LOOPBACK_EN adds CTRL bit 2 (loop), which feeds MOSI back into the receive path.
module sd_spi_master #(
    parameter int         XLEN      = 32,
    parameter logic [7:0] DIV_RESET = 8'd62
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              EN,
    input  logic [1:0]        ADDR,
    input  logic              WR,
    input  logic [XLEN/8-1:0] BE,
    input  logic [XLEN-1:0]   DATAI,
    output logic [XLEN-1:0]   DATAO,
    output logic              READY,
    output logic              SPI_SCLK,
    output logic              SPI_MOSI,
    input  logic              SPI_MISO,
    output logic              SPI_CS_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      div, wdiv, cnt, shift, rx_data;
    logic [2:0]      bit_cnt;
    logic            rx_valid, overrun, loop, busy, wr_data, half_done, miso_bit;
    logic [XLEN-1:0] rd_mux;
    logic            unused_bits;

    assign busy        = (state != IDLE);
    assign wr_data     = EN && WR && (ADDR == 2'd0) && BE[0];
    assign half_done   = (cnt == wdiv);
    assign unused_bits = ^{DATAI, BE};

`ifdef SPI_LOOPBACK_EN
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)
            loop <= 1'b0;
        else if (EN && WR && (ADDR == 2'd2) && BE[0])
            loop <= DATAI[2];
    end
    assign miso_bit = loop ? SPI_MOSI : SPI_MISO;
`else
    assign loop     = 1'b0;
    assign miso_bit = SPI_MISO;
`endif

    always_comb begin
        rd_mux = '0;
        case (ADDR)
            2'd0: rd_mux[7:0] = rx_data;
            2'd1: rd_mux[2:0] = {overrun, rx_valid, busy};
            2'd2: begin
                rd_mux[15:8] = div;
                rd_mux[2]    = loop;
                rd_mux[0]    = SPI_CS_N;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (wr_data) state_nxt = LOW;
            LOW:  if (half_done) state_nxt = HIGH;
            HIGH: if (half_done) state_nxt = (bit_cnt == 3'd7) ? DONE : LOW;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            DATAO    <= '0;
            READY    <= 1'b0;
            SPI_SCLK <= 1'b0;
            SPI_MOSI <= 1'b1;
            SPI_CS_N <= 1'b1;
            div      <= DIV_RESET;
            wdiv     <= DIV_RESET;
            cnt      <= 8'd0;
            shift    <= 8'd0;
            rx_data  <= 8'd0;
            bit_cnt  <= 3'd0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            READY <= EN;
            if (EN && !WR)
                DATAO <= rd_mux;
            if (EN && WR) begin
                case (ADDR)
                    2'd0: if (BE[0] && busy) overrun <= 1'b1;
                    2'd1: if (BE[0] && DATAI[2]) overrun <= 1'b0;
                    2'd2: begin
                        if (BE[0]) SPI_CS_N <= DATAI[0];
                        if (BE[1]) div <= DATAI[15:8];
                    end
                    default: ;
                endcase
            end
            if (EN && !WR && (ADDR == 2'd0))
                rx_valid <= 1'b0;
            // Received bits enter at the LSB on each rising edge, so shift[7]
            // always holds the next bit to transmit after the preceding fall.
            case (state)
                IDLE: if (wr_data) begin
                    shift    <= DATAI[7:0];
                    SPI_MOSI <= DATAI[7];
                    bit_cnt  <= 3'd0;
                    cnt      <= 8'd0;
                    wdiv     <= div;
                end
                LOW: begin
                    if (half_done) begin
                        SPI_SCLK <= 1'b1;
                        shift    <= {shift[6:0], miso_bit};
                        cnt      <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        SPI_SCLK <= 1'b0;
                        cnt      <= 8'd0;
                        if (bit_cnt != 3'd7) begin
                            SPI_MOSI <= shift[7];
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                    SPI_MOSI <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
